// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS unified-memory port arbiter.
// Holds the arbiter state encoding, port-owner encoding and timing defaults.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned DEF_MEM_LAT      = 1;
  localparam int unsigned DEF_MAX_D_STREAK = 4;

  // Both the latency counter and the streak counter cover the range 0..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the fetch (I) and memory (D) stages.
// D has priority; a bounded D streak guarantees that fetch makes progress.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_LAT      = DEF_MEM_LAT,
  parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_i,
  output logic          gnt_d
);

  localparam logic [CNT_W-1:0] LatLoad   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] StreakMax = CNT_W'(MAX_D_STREAK);

  arb_state_t       state, nextState;
  owner_t           owner;
  logic             ownerWe;
  logic [CNT_W-1:0] latCnt;
  logic [CNT_W-1:0] streak;
  logic             grantD, grantI, capture;

  // NOTE: always_comb assigns every output a default before the case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_req || streak < StreakMax)) begin
          grantD    = 1'b1;
          nextState = ISSUE;
        end else if (i_req) begin
          grantI    = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: nextState = WAIT;
      WAIT: begin
        // mem_rdata is valid in the last WAIT cycle, MEM_LAT cycles after mem_en.
        if (latCnt == '0) begin
          capture   = 1'b1;
          nextState = RESP;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: data registers are reset too, because rdata and the memory-side outputs must read 0 during and after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_I;
      ownerWe   <= 1'b0;
      latCnt    <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      gnt_i     <= 1'b0;
      gnt_d     <= 1'b0;
    end else begin
      mem_en  <= grantD | grantI;
      mem_we  <= (grantD && d_we) ? d_be : 4'b0000;
      i_ready <= capture && (owner == OWN_I);
      d_ready <= capture && (owner == OWN_D);
      gnt_i   <= grantI | (gnt_i && state != RESP);
      gnt_d   <= grantD | (gnt_d && state != RESP);

      if (grantD) begin
        owner    <= OWN_D;
        ownerWe  <= d_we;
        mem_addr <= d_addr;
        if (d_we) mem_wdata <= d_wdata;
      end else if (grantI) begin
        owner    <= OWN_I;
        ownerWe  <= 1'b0;
        mem_addr <= i_addr;
      end

      if (state == ISSUE) begin
        latCnt <= LatLoad;
      end else if (state == WAIT && latCnt != '0) begin
        latCnt <= latCnt - 1'b1;
      end

      // Writes complete like reads but leave d_rdata untouched.
      if (capture) begin
        if (owner == OWN_I) begin
          i_rdata <= mem_rdata;
        end else if (!ownerWe) begin
          d_rdata <= mem_rdata;
        end
      end

      if (grantD) begin
        if (!i_req) begin
          streak <= '0;
        end else if (streak != StreakMax) begin
          streak <= streak + 1'b1;
        end
      end else if (grantI) begin
        streak <= '0;
      end
    end
  end

endmodule
